// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the width of the word-count field carried in the byte stream header.
package instr_mem_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed byte image into instruction memory as 32-bit
// little-endian words, holding the datapath in reset until the load completes.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(1) << ADDR_W;

  state_t           state;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      shreg;
  logic             accept;
  logic [LEN_W-1:0] len_in;

  assign accept   = in_valid && in_ready;
  assign len_in   = {in_data, len_lo};

  assign in_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign busy     = in_ready;
  assign done     = (state == DONE);
  assign err      = (state == ERR);
  // The final word is written during the first DONE cycle; release the core after it.
  assign cpu_rst_n = (state == DONE) && !mem_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len_lo    <= '0;
      len       <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN_LO;
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len <= len_in;
            if (len_in == '0)
              state <= DONE;
            else if ({1'b0, len_in} > MAX_WORDS)
              state <= ERR;
            else
              state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {in_data, shreg[23:8]};
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx[ADDR_W-1:0];
              mem_wdata <= {in_data, shreg};
              word_idx  <= word_idx + 16'd1;
              if (word_idx + 16'd1 == len)
                state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued as words
// are streamed in and retired by a monitor watching mem_we.
module tb_instr_mem_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int failures = 0;
  logic [ADDR_W+31:0] exp_q[$];

  instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Retire one expected write per observed strobe.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, expected no write", mem_addr, mem_wdata);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("[TB] FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_addr, mem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL in_ready_timeout: got in_ready=0, expected 1 within 100 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input int addr, input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (gap > 0 && i < 3) begin
        idle();
        repeat (gap) @(negedge clk);
      end
    end
    exp_q.push_back({addr[ADDR_W-1:0], w});
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b/%b/%h/%h/%b/%b/%b/%b, expected all zero",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got busy=%b in_ready=%b, expected 0/0", busy, in_ready);
    end
  endtask

  task automatic test_two_words();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_len_lo: got busy=%b in_ready=%b, expected 1/1", busy, in_ready);
    end
    send_len(16'd2);
    send_word(0, 32'h12345678, 0);
    send_word(1, 32'hDEADBEEF, 0);
    idle();
    checks++;
    if (done !== 1'b1 || mem_we !== 1'b1 || cpu_rst_n !== 1'b0) begin
      failures++;
      $display("[TB] FAIL first_done_cycle: got done=%b mem_we=%b cpu_rst_n=%b, expected 1/1/0", done, mem_we, cpu_rst_n);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL two_words_done: got done=%b cpu_rst_n=%b busy=%b, expected 1/1/0", done, cpu_rst_n, busy);
    end
    checks++;
    if (mem_addr !== 6'd1 || mem_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL hold_last_write: got addr=%0d data=%h, expected 1/deadbeef", mem_addr, mem_wdata);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL two_words_count: got %0d pending writes, expected 0", exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    pulse_start();
    send_len(16'd0);
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_len: got done=%b cpu_rst_n=%b err=%b, expected 1/1/0", done, cpu_rst_n, err);
    end
  endtask

  task automatic test_overflow();
    pulse_start();
    send_len(16'd65);
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overflow: got err=%b done=%b cpu_rst_n=%b in_ready=%b, expected 1/0/0/0",
               err, done, cpu_rst_n, in_ready);
    end
    pulse_start();
    send_len(16'd1);
    send_word(0, 32'hCAFEF00D, 0);
    idle();
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || cpu_rst_n !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL reload_after_err: got done=%b err=%b cpu_rst_n=%b pending=%0d, expected 1/0/1/0",
               done, err, cpu_rst_n, exp_q.size());
    end
  endtask

  task automatic test_stall();
    pulse_start();
    send_len(16'd1);
    send_byte(8'h01);
    idle();
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_hold: got busy=%b done=%b, expected 1/0", busy, done);
    end
    for (int i = 1; i < 4; i++) begin
      send_byte(8'(i + 1));
      if (i < 3) begin
        idle();
        repeat (5) @(negedge clk);
      end
    end
    exp_q.push_back({6'd0, 32'h04030201});
    idle();
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL stall_done: got done=%b pending=%0d, expected 1/0", done, exp_q.size());
    end
  endtask

  task automatic test_start_in_data();
    pulse_start();
    send_len(16'd2);
    send_word(0, 32'h0BADF00D, 0);
    idle();
    pulse_start();
    send_word(1, 32'h13579BDF, 0);
    idle();
    checks++;
    if (done !== 1'b1 || mem_we !== 1'b1) begin
      failures++;
      $display("[TB] FAIL start_ignored: got done=%b mem_we=%b, expected 1/1", done, mem_we);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL start_ignored_count: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_len(16'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    idle();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err} !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset: got %b/%b/%h/%h/%b/%b/%b/%b, expected all zero",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: got busy=%b mem_we=%b, expected 0/0", busy, mem_we);
    end
    pulse_start();
    send_len(16'd1);
    send_word(0, 32'hDDCCBBAA, 0);
    idle();
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL partial_discarded: got done=%b pending=%0d, expected 1/0", done, exp_q.size());
    end
  endtask

  task automatic test_full();
    pulse_start();
    send_len(16'd64);
    for (int w = 0; w < 64; w++) begin
      logic [31:0] d;
      d = $urandom;
      send_word(w, d, 0);
    end
    idle();
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || mem_addr !== 6'd63 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL full_load: got done=%b err=%b addr=%0d pending=%0d, expected 1/0/63/0",
               done, err, mem_addr, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_overflow();
    test_stall();
    test_start_in_data();
    test_reset_mid();
    test_full();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, instruction-memory word-address width (2^ADDR_W words).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle load request.
REQ-005 SHALL have port in_valid  input  1  byte-stream valid.
REQ-006 SHALL have port in_data  input  8  byte-stream data.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 SHALL have port mem_wdata  output  32  instruction-memory write word.
REQ-011 SHALL have port cpu_rst_n  output  1  datapath reset, active-low.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  last load completed successfully.
REQ-014 SHALL have port err  output  1  last load rejected (length overflow).

Function
REQ-015 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR.
REQ-016 SHALL transfer a byte only when in_valid and in_ready are both 1 on a posedge.
REQ-017 SHALL drive in_ready=1 only in LEN_LO, LEN_HI, DATA; 0 otherwise.
REQ-018 SHALL, in IDLE, DONE or ERR, move to LEN_LO on start=1; start SHALL be ignored in all other states.
REQ-019 SHALL capture byte 0 as length bits [7:0] (LEN_LO->LEN_HI) and byte 1 as bits [15:8]; N = 16-bit word count.
REQ-020 SHALL, on leaving LEN_HI, go to DONE if N=0 (no writes), to ERR if N>2^ADDR_W (no writes), else to DATA.
REQ-021 SHALL assemble data bytes little-endian: 1st byte -> [7:0], 4th byte -> [31:24].
REQ-022 SHALL, one cycle after the 4th byte of a word is accepted, pulse mem_we=1 for exactly one cycle with mem_addr=word index (0-based) and mem_wdata=assembled word.
REQ-023 SHALL keep in_ready=1 during the write cycle (no memory backpressure); the next word's bytes are accepted concurrently.
REQ-024 SHALL go DATA->DONE on acceptance of the 4th byte of word N-1; the final mem_we pulse occurs in the first DONE cycle.
REQ-025 SHALL hold mem_addr and mem_wdata at last written values when mem_we=0.
REQ-026 SHALL drive cpu_rst_n=1 only in DONE and after the final mem_we pulse has completed; 0 in all other states.
REQ-027 SHALL drive busy=1 in LEN_LO, LEN_HI, DATA; done=1 only in DONE; err=1 only in ERR.
REQ-028 SHALL, with in_valid=0, stall indefinitely in any receive state without changing partial word or counters.
REQ-029 SHALL handle N=2^ADDR_W exactly: final address 2^ADDR_W-1, no wrap, then DONE.

Reset
REQ-030 SHALL, on rst=0 (any state, including mid-word), asynchronously enter IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0; a partial word SHALL be discarded without writing.
REQ-031 SHALL begin operation on the first posedge after rst returns to 1.

Structure
REQ-032 SHALL take state encodings and the length-field width (16) from the shared datapath package.
REQ-033 SHALL be a single module with no sub-modules; the byte-assembly shift register is inline.

Verification
REQ-034 Reset, then start, bytes 02 00 | 78 56 34 12 | EF BE AD DE -> mem_we at addr 0 data 0x12345678, addr 1 data 0xDEADBEEF, done=1, cpu_rst_n=1.
REQ-035 start, bytes 00 00 -> zero mem_we pulses, DONE, cpu_rst_n=1.
REQ-036 ADDR_W=6, start, bytes 41 00 (N=65) -> ERR, err=1, cpu_rst_n=0, no mem_we; then start with valid length -> loads normally.
REQ-037 N=1, in_valid deasserted 5 cycles between each data byte -> single write 0x04030201 at addr 0 for bytes 01 02 03 04.
REQ-038 rst=0 after 2 data bytes of word 0 -> immediate IDLE, all outputs at reset values, no mem_we ever.
REQ-039 start pulsed in DATA -> ignored; load completes with the original N.
